// File: rtl/i2c_pointer_slave.sv
// I2C target for the pointer-based register protocol: oversampled START/STOP
// detection, 7-bit address match, pointer byte, then auto-incrementing
// register writes or reads.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus free or not yet started
// ADDR      | shifting in the address byte
// ACK       | driving our ACK bit; branch on the fall that ends it
// PTR       | shifting in the register pointer byte
// WDATA     | shifting in a write data byte
// TX        | shifting out a read data byte
// RACK      | waiting for the master's ACK/NACK after a read byte
// WAIT_STOP | not addressed or read ended; ignore bits until START/STOP
module i2c_pointer_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic       PT_CK,
  input  logic       RESET,
  input  logic [6:0] SLAVE_ADDRESS,
  input  logic       SCLI,
  input  logic       SDAI,
  output logic       SDAO,
  output logic [7:0] POINTER,
  output logic       WR_EN,
  output logic [7:0] WR_DATA,
  input  logic [7:0] RD_DATA,
  output logic       RD_STB,
  output logic       BUSY
);

  // Fewer than two stages would leave the pins metastable-prone.
  localparam int         SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [7:0] PTR_INC = (AUTO_INC != 0) ? 8'd1 : 8'd0;

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK, PTR, WDATA, TX, RACK, WAIT_STOP
  } state_t;

  logic [SYNC_N-1:0] scl_sync_q, sda_sync_q;
  logic              scl_dly_q, sda_dly_q;
  logic              scl_s, sda_s;
  logic              scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  state_t     ack_next_q, ack_next_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] pointer_q, pointer_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       sdao_q, sdao_d;
  logic       wr_en_q, wr_en_d;
  logic       rd_stb_q, rd_stb_d;
  logic       busy_q, busy_d;
  logic       inc_pend_q, inc_pend_d;

  // Pin synchronizers plus one delay stage for edge detection; idle-high reset.
  always_ff @(posedge PT_CK or posedge RESET) begin
    if (RESET) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_N-2:0], SCLI};
      sda_sync_q <= {sda_sync_q[SYNC_N-2:0], SDAI};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_N-1];
  assign sda_s     = sda_sync_q[SYNC_N-1];
  assign scl_rise  = ~scl_dly_q & scl_s;
  assign scl_fall  = scl_dly_q & ~scl_s;
  assign start_det = scl_dly_q & scl_s & sda_dly_q & ~sda_s;
  assign stop_det  = scl_dly_q & scl_s & ~sda_dly_q & sda_s;

  // FSM and datapath registers.
  always_ff @(posedge PT_CK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      ack_next_q <= PTR;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      pointer_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      sdao_q     <= 1'b1;
      wr_en_q    <= 1'b0;
      rd_stb_q   <= 1'b0;
      busy_q     <= 1'b0;
      inc_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_next_q <= ack_next_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pointer_q  <= pointer_d;
      wr_data_q  <= wr_data_d;
      sdao_q     <= sdao_d;
      wr_en_q    <= wr_en_d;
      rd_stb_q   <= rd_stb_d;
      busy_q     <= busy_d;
      inc_pend_q <= inc_pend_d;
    end
  end

  // Next-state logic; bus conditions override whatever the FSM was doing.
  always_comb begin
    state_d    = state_q;
    ack_next_d = ack_next_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pointer_d  = pointer_q;
    wr_data_d  = wr_data_q;
    sdao_d     = sdao_q;
    wr_en_d    = 1'b0;
    rd_stb_d   = 1'b0;
    busy_d     = busy_q;
    inc_pend_d = 1'b0;

    // A written byte advances the pointer one cycle after its strobe.
    if (inc_pend_q) pointer_d = pointer_q + PTR_INC;

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sdao_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sdao_d    = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR, PTR, WDATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              case (state_q)
                ADDR: begin
                  if (shift_q[6:0] == SLAVE_ADDRESS) begin
                    busy_d     = 1'b1;
                    ack_next_d = sda_s ? TX : PTR;
                  end else begin
                    state_d = WAIT_STOP;
                    sdao_d  = 1'b1;
                  end
                end
                PTR: begin
                  pointer_d  = {shift_q[6:0], sda_s};
                  ack_next_d = WDATA;
                end
                default: begin
                  wr_data_d  = {shift_q[6:0], sda_s};
                  wr_en_d    = 1'b1;
                  inc_pend_d = 1'b1;
                  ack_next_d = WDATA;
                end
              endcase
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sdao_d    = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ACK;
          end
        end
        ACK: begin
          if (scl_fall) begin
            if (ack_next_q == TX) begin
              shift_d   = {RD_DATA[6:0], 1'b0};
              sdao_d    = RD_DATA[7];
              rd_stb_d  = 1'b1;
              bit_cnt_d = 4'd1;
              state_d   = TX;
            end else begin
              sdao_d    = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = ack_next_q;
            end
          end
        end
        // bit_cnt counts bits already placed on SDAO.
        TX: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sdao_d    = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = RACK;
            end else begin
              sdao_d    = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // bit_cnt != 0 here marks that the master has ACKed.
        RACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              pointer_d = pointer_q + PTR_INC;
              bit_cnt_d = 4'd1;
            end else begin
              sdao_d  = 1'b1;
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d   = {RD_DATA[6:0], 1'b0};
            sdao_d    = RD_DATA[7];
            rd_stb_d  = 1'b1;
            bit_cnt_d = 4'd1;
            state_d   = TX;
          end
        end
        WAIT_STOP: sdao_d = 1'b1;
        default:   state_d = IDLE;
      endcase
    end
  end

  assign SDAO    = sdao_q;
  assign POINTER = pointer_q;
  assign WR_EN   = wr_en_q;
  assign WR_DATA = wr_data_q;
  assign RD_STB  = rd_stb_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_i2c_pointer_slave.sv
// Directed bench: a bit-banged I2C master drives two targets (0x48 with
// auto-increment, 0x4A without) on a shared wired-AND SDA line.
module tb_i2c_pointer_slave;

  localparam int Q = 10;

  logic       PT_CK = 1'b0;
  logic       RESET = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sdao, wr_en, rd_stb, busy;
  logic [7:0] pointer, wr_data, rd_data;
  logic       sdao_ni, wr_en_ni, rd_stb_ni, busy_ni;
  logic [7:0] pointer_ni, wr_data_ni;
  logic [7:0] regs [256];

  int tests_run    = 0;
  int tests_failed = 0;
  int wr_cnt = 0, rd_cnt = 0, low_cnt = 0, wr_cnt_ni = 0, rd_cnt_ni = 0;
  logic [7:0] wr_data_log [16];
  logic [7:0] wr_ptr_log  [16];
  logic [7:0] wr_data_ni_last = 8'h00;

  always #5 PT_CK = ~PT_CK;

  assign sda_line = sda_m & sdao & sdao_ni;

  always_comb rd_data = regs[pointer];

  i2c_pointer_slave #(.SYNC_STAGES(2), .AUTO_INC(1)) u_dut (
    .PT_CK(PT_CK), .RESET(RESET), .SLAVE_ADDRESS(7'h48),
    .SCLI(scl_m), .SDAI(sda_line), .SDAO(sdao), .POINTER(pointer),
    .WR_EN(wr_en), .WR_DATA(wr_data), .RD_DATA(rd_data),
    .RD_STB(rd_stb), .BUSY(busy));

  i2c_pointer_slave #(.SYNC_STAGES(2), .AUTO_INC(0)) u_dut_ni (
    .PT_CK(PT_CK), .RESET(RESET), .SLAVE_ADDRESS(7'h4A),
    .SCLI(scl_m), .SDAI(sda_line), .SDAO(sdao_ni), .POINTER(pointer_ni),
    .WR_EN(wr_en_ni), .WR_DATA(wr_data_ni), .RD_DATA(8'h00),
    .RD_STB(rd_stb_ni), .BUSY(busy_ni));

  // Strobe monitors and write log.
  always @(posedge PT_CK) begin
    if (wr_en) begin
      wr_data_log[wr_cnt[3:0]] <= wr_data;
      wr_ptr_log[wr_cnt[3:0]]  <= pointer;
      wr_cnt <= wr_cnt + 1;
    end
    if (rd_stb)   rd_cnt <= rd_cnt + 1;
    if (!sdao)    low_cnt <= low_cnt + 1;
    if (wr_en_ni) begin
      wr_cnt_ni       <= wr_cnt_ni + 1;
      wr_data_ni_last <= wr_data_ni;
    end
    if (rd_stb_ni) rd_cnt_ni <= rd_cnt_ni + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge PT_CK);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, output logic sdao_ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wq();
      scl_m = 1'b1; wq();
      scl_m = 1'b0;
    end
    sda_m = 1'b1; wq();
    scl_m = 1'b1;
    repeat (Q/2) @(negedge PT_CK);
    ack      = sda_line;
    sdao_ack = sdao;
    repeat (Q - Q/2) @(negedge PT_CK);
    scl_m = 1'b0; wq();
  endtask

  task automatic read_byte(input logic ack_m, output logic [7:0] d, output logic sdao_after);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq();
      scl_m = 1'b1;
      repeat (Q/2) @(negedge PT_CK);
      d[i] = sda_line;
      repeat (Q - Q/2) @(negedge PT_CK);
      scl_m = 1'b0;
    end
    sda_m = ack_m ? 1'b0 : 1'b1; wq();
    scl_m = 1'b1; wq();
    scl_m = 1'b0;
    sda_m = 1'b1; wq();
    sdao_after = sdao;
  endtask

  initial begin
    logic       ack, sa, sd;
    logic [7:0] d;
    int         w0, r0, l0, wn0;

    for (int i = 0; i < 256; i++) regs[i] = i[7:0];
    regs[8'h20] = 8'h3C;
    regs[8'h21] = 8'hC3;

    // Reset state
    RESET = 1'b1;
    repeat (4) @(negedge PT_CK);
    check("rst_sdao",    {31'd0, sdao},    32'h1);
    check("rst_pointer", {24'd0, pointer}, 32'h00);
    check("rst_wr_en",   {31'd0, wr_en},   32'h0);
    check("rst_wr_data", {24'd0, wr_data}, 32'h00);
    check("rst_rd_stb",  {31'd0, rd_stb},  32'h0);
    check("rst_busy",    {31'd0, busy},    32'h0);
    RESET = 1'b0;
    repeat (10) @(negedge PT_CK);

    // Pointer-only write
    w0 = wr_cnt;
    i2c_start();
    send_byte(8'h90, ack, sa);
    check("t1_addr_ack_sdao", {31'd0, sa}, 32'h0);
    check("t1_busy_after_addr", {31'd0, busy}, 32'h1);
    send_byte(8'h05, ack, sa);
    check("t1_ptr_ack_sdao", {31'd0, sa}, 32'h0);
    check("t1_pointer", {24'd0, pointer}, 32'h05);
    i2c_stop();
    repeat (5) @(negedge PT_CK);
    check("t1_busy_after_stop", {31'd0, busy}, 32'h0);
    check("t1_no_wr", wr_cnt - w0, 0);

    // Two-byte write with auto-increment
    w0 = wr_cnt;
    i2c_start();
    send_byte(8'h90, ack, sa);
    send_byte(8'h10, ack, sa);
    send_byte(8'hAA, ack, sa);
    check("t2_data1_ack", {31'd0, ack}, 32'h0);
    send_byte(8'h55, ack, sa);
    i2c_stop();
    repeat (5) @(negedge PT_CK);
    check("t2_wr_count", wr_cnt - w0, 2);
    check("t2_wr0_data", {24'd0, wr_data_log[w0[3:0]]}, 32'hAA);
    check("t2_wr0_ptr",  {24'd0, wr_ptr_log[w0[3:0]]},  32'h10);
    check("t2_wr1_data", {24'd0, wr_data_log[w0[3:0] + 4'd1]}, 32'h55);
    check("t2_wr1_ptr",  {24'd0, wr_ptr_log[w0[3:0] + 4'd1]},  32'h11);
    check("t2_pointer", {24'd0, pointer}, 32'h12);

    // Set pointer, repeated START, read two bytes (ACK then NACK)
    r0 = rd_cnt;
    i2c_start();
    send_byte(8'h90, ack, sa);
    send_byte(8'h20, ack, sa);
    i2c_start();
    send_byte(8'h91, ack, sa);
    check("t3_raddr_ack", {31'd0, ack}, 32'h0);
    read_byte(1'b1, d, sd);
    check("t3_byte0", {24'd0, d}, 32'h3C);
    read_byte(1'b0, d, sd);
    check("t3_byte1", {24'd0, d}, 32'hC3);
    check("t3_sdao_after_nack", {31'd0, sd}, 32'h1);
    i2c_stop();
    repeat (5) @(negedge PT_CK);
    check("t3_rd_stb_count", rd_cnt - r0, 2);
    check("t3_pointer", {24'd0, pointer}, 32'h21);

    // Address mismatch
    w0 = wr_cnt; l0 = low_cnt;
    i2c_start();
    send_byte(8'h92, ack, sa);
    check("t4_nack", {31'd0, ack}, 32'h1);
    check("t4_busy", {31'd0, busy}, 32'h0);
    send_byte(8'h05, ack, sa);
    i2c_stop();
    repeat (5) @(negedge PT_CK);
    check("t4_sdao_never_low", low_cnt - l0, 0);
    check("t4_pointer", {24'd0, pointer}, 32'h21);
    check("t4_no_wr", wr_cnt - w0, 0);

    // Pointer wrap with auto-increment
    w0 = wr_cnt;
    i2c_start();
    send_byte(8'h90, ack, sa);
    send_byte(8'hFF, ack, sa);
    send_byte(8'h77, ack, sa);
    i2c_stop();
    repeat (5) @(negedge PT_CK);
    check("t5_wr_count", wr_cnt - w0, 1);
    check("t5_wr_ptr",  {24'd0, wr_ptr_log[w0[3:0]]},  32'hFF);
    check("t5_wr_data", {24'd0, wr_data_log[w0[3:0]]}, 32'h77);
    check("t5_pointer_wrap", {24'd0, pointer}, 32'h00);

    // Same sequence on the non-incrementing target
    wn0 = wr_cnt_ni;
    i2c_start();
    send_byte(8'h94, ack, sa);
    check("t5n_addr_ack", {31'd0, ack}, 32'h0);
    send_byte(8'hFF, ack, sa);
    send_byte(8'h77, ack, sa);
    i2c_stop();
    repeat (5) @(negedge PT_CK);
    check("t5n_wr_count", wr_cnt_ni - wn0, 1);
    check("t5n_wr_data", {24'd0, wr_data_ni_last}, 32'h77);
    check("t5n_pointer_hold", {24'd0, pointer_ni}, 32'hFF);
    check("t5n_busy", {31'd0, busy_ni}, 32'h0);
    check("t5n_no_rd_stb", rd_cnt_ni, 0);
    check("t5_main_pointer", {24'd0, pointer}, 32'h00);

    // Async reset while driving a 0 data bit
    i2c_start();
    send_byte(8'h91, ack, sa);
    check("t6_tx_bit_low", {31'd0, sdao}, 32'h0);
    #1 RESET = 1'b1;
    #1;
    check("t6_async_sdao", {31'd0, sdao}, 32'h1);
    check("t6_async_busy", {31'd0, busy}, 32'h0);
    repeat (4) @(negedge PT_CK);
    RESET = 1'b0;
    repeat (5) @(negedge PT_CK);
    i2c_start();
    send_byte(8'h90, ack, sa);
    check("t6_addr_ack_after_rst", {31'd0, sa}, 32'h0);
    send_byte(8'h33, ack, sa);
    check("t6_ptr_ack_after_rst", {31'd0, sa}, 32'h0);
    i2c_stop();
    repeat (5) @(negedge PT_CK);
    check("t6_pointer", {24'd0, pointer}, 32'h33);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2c_pointer_slave.md
Name: i2c_pointer_slave

Overview:
- I2C target (responder) for the pointer-based register protocol that our I2C master blocks drive.
- Oversamples SCL/SDA on the system clock and detects START, STOP and repeated START.
- Matches a 7-bit address, takes the first written byte as the register pointer, then writes or reads register bytes with pointer auto-increment.
- Sits between the board I2C pins (open-drain pad outside this block) and a local register file.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on SCLI and SDAI before edge detection (minimum 2).
- AUTO_INC, 1, 1 = POINTER increments after each data byte; 0 = POINTER holds.

Ports:
- PT_CK  in  1  system clock; must be at least 8x the SCL rate.
- RESET  in  1  asynchronous reset, active-high.
- SLAVE_ADDRESS  in  7  device address compared with bits [7:1] of the address byte.
- SCLI  in  1  SCL pin sample.
- SDAI  in  1  SDA pin sample.
- SDAO  out  1  SDA drive: 0 = pull low, 1 = release.
- POINTER  out  8  current register pointer.
- WR_EN  out  1  one-cycle write strobe to the register file.
- WR_DATA  out  8  write data; valid while WR_EN=1.
- RD_DATA  in  8  register-file data at POINTER; combinational from POINTER, stable by the next PT_CK edge.
- RD_STB  out  1  one-cycle pulse when RD_DATA is loaded into the TX shifter.
- BUSY  out  1  high from an address-matched START until STOP.

Behaviour:
- Reset (async, any state): SDAO=1, POINTER=0, WR_EN=0, WR_DATA=0, RD_STB=0, BUSY=0, state=IDLE, bit counter=0, sync flops=1.
- Edge detection uses the synchronized SCL/SDA plus one delay stage. SCL rise/fall = change between the delayed and current samples.
- START = SDA 1->0 while SCL is high in both samples. STOP = SDA 0->1 while SCL is high in both samples.
- START/STOP take precedence over any state.
  - START from any state: go to ADDR, clear bit counter, SDAO=1.
  - STOP from any state: go to IDLE, SDAO=1, BUSY=0.
- Data is sampled on SCL rise. SDAO changes only on SCL fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. On the 8th rise, compare bits [7:1] with SLAVE_ADDRESS.
    - Match: at the next fall, SDAO=0 and enter ACK; BUSY=1; latch R/W (bit 0).
    - Mismatch: enter WAIT_STOP with SDAO=1.
  - ACK: at the next SCL fall, SDAO=1, then branch:
    - after address with W: go to PTR;
    - after address with R: go to TX;
    - after the pointer byte or a data byte: go to WDATA.
  - PTR: shift 8 bits. On the 8th rise, load POINTER. ACK as above.
  - WDATA: shift 8 bits. On the 8th rise: WR_DATA=byte and WR_EN=1 for one cycle (write address = POINTER). Next cycle: POINTER+=AUTO_INC. ACK as above.
  - TX: on the SCL fall that ends the address ACK, load shifter from RD_DATA, pulse RD_STB, drive MSB on SDAO. Each later fall shifts out the next bit. After the 8th bit's fall, SDAO=1 and go to RACK.
  - RACK: sample SDAI on the SCL rise.
    - 0 (ACK): POINTER+=AUTO_INC; at the following fall reload from RD_DATA (new POINTER), pulse RD_STB, drive MSB; stay in TX.
    - 1 (NACK): go to WAIT_STOP with SDAO=1.
  - WAIT_STOP: SDAO=1; ignore bits until START or STOP.
- POINTER is 8-bit and wraps 0xFF -> 0x00.
- Repeated START keeps POINTER, so a write-pointer then repeated-START read returns data from the new pointer.
- A STOP or START arriving mid-byte discards the partial byte: no WR_EN, POINTER unchanged.
- SDAO is never driven low outside an ACK slot or a TX bit. After reset or STOP, SDAO=1 by the next cycle.

Test Plan:
- SLAVE_ADDRESS=0x48. Bench sends START, 0x90, 0x05, STOP -> SDAO=0 in both ACK slots; POINTER=0x05; BUSY returns to 0 after STOP; no WR_EN.
- START, 0x90, 0x10, 0xAA, 0x55, STOP -> WR_EN pulses twice: WR_DATA=0xAA at POINTER 0x10, then WR_DATA=0x55 at POINTER 0x11; final POINTER=0x12.
- Bench sets POINTER=0x20, register model has 0x20=0x3C and 0x21=0xC3. Sequence: repeated START, 0x91, master ACK, master NACK, STOP -> bytes read are 0x3C then 0xC3; RD_STB pulses twice; SDAO=1 after the NACK.
- START, 0x92, 0x05 (address mismatch) -> SDAO stays 1 throughout; POINTER unchanged; BUSY=0; no WR_EN.
- POINTER=0xFF, write 0x77 -> WR_EN with POINTER 0xFF; POINTER becomes 0x00. Same sequence with AUTO_INC=0 -> POINTER stays 0xFF.
- Assert RESET while SDAO=0 during a TX bit -> SDAO=1 immediately (asynchronous). After release, a full address write is ACKed normally.
